mouse_click_decoder: RTL and testbench

Consumes the 2-bit mouse button status driven by the CPU-written mouse status PIO (bit 0 = left, bit 1 = right) and turns the raw levels into discrete click events for the game logic. Per button, it classifies gestures as CLICK, DOUBLE, HOLD_START or HOLD_END using cycle counters. It queues events in a 4-deep FIFO with a valid/ready output handshake. It sits between the PIO output port and the cursor/game control logic in the Imersiv SoC fabric.

---
 rtl/mouse_click_pkg.sv | 36 +++
 rtl/mouse_btn_fsm.sv | 117 +++++++++++
 rtl/mouse_click_decoder.sv | 139 +++++++++++++
 tb/tb_mouse_click_decoder.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mouse_click_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mouse_click_pkg
// Description : Shared types and constants for the mouse click decoder:
//               event codes, per-button gesture states, FIFO entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package mouse_click_pkg;

  // Number of queued events between the decoder and the game logic.
  localparam int unsigned FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    EV_NONE    = 3'd0,
    CLICK      = 3'd1,
    DOUBLE     = 3'd2,
    HOLD_START = 3'd3,
    HOLD_END   = 3'd4
  } ev_code_t;

  // WAIT2/PRESS2 are only reachable when double-click detection is built in.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRESSED = 3'd1,
    ST_HELD    = 3'd2,
    ST_WAIT2   = 3'd3,
    ST_PRESS2  = 3'd4
  } btn_state_t;

  typedef struct packed {
    logic     btn;
    ev_code_t code;
  } fifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/mouse_btn_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mouse_btn_fsm
// Description : Gesture classifier for one mouse button. Turns the
//               synchronized level and its press edge into a one-cycle event
//               strobe with CLICK / DOUBLE / HOLD_START / HOLD_END code.
//               Double-click support is built when MOUSE_CLICK_DBLCLICK_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module mouse_btn_fsm
  import mouse_click_pkg::*;
#(
  parameter int unsigned DBL_WINDOW  = 12_500_000,
  parameter int unsigned HOLD_CYCLES = 25_000_000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     level,
  input  logic     press_edge,
  output logic     ev_stb,
  output ev_code_t ev_code
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`ifdef MOUSE_CLICK_DBLCLICK_EN
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_WINDOW - 1);
`endif

  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ev_stb_q, ev_stb_d;
  ev_code_t         ev_code_q, ev_code_d;

  // Next-state, event and gesture-counter logic.
  always_comb begin
    state_d   = state_q;
    ev_stb_d  = 1'b0;
    ev_code_d = EV_NONE;
    case (state_q)
      ST_IDLE: begin
        if (press_edge) state_d = ST_PRESSED;
      end
      ST_PRESSED: begin
        // A release on the very cycle the hold limit is reached still counts
        // as a short press.
        if (!level) begin
`ifdef MOUSE_CLICK_DBLCLICK_EN
          state_d = ST_WAIT2;
`else
          ev_stb_d  = 1'b1;
          ev_code_d = CLICK;
          state_d   = ST_IDLE;
`endif
        end else if (cnt_q == HOLD_LAST) begin
          ev_stb_d  = 1'b1;
          ev_code_d = HOLD_START;
          state_d   = ST_HELD;
        end
      end
      ST_HELD: begin
        if (!level) begin
          ev_stb_d  = 1'b1;
          ev_code_d = HOLD_END;
          state_d   = ST_IDLE;
        end
      end
`ifdef MOUSE_CLICK_DBLCLICK_EN
      ST_WAIT2: begin
        // A second press on the last window cycle beats the timeout.
        if (press_edge) begin
          ev_stb_d  = 1'b1;
          ev_code_d = DOUBLE;
          state_d   = ST_PRESS2;
        end else if (cnt_q == DBL_LAST) begin
          ev_stb_d  = 1'b1;
          ev_code_d = CLICK;
          state_d   = ST_IDLE;
        end
      end
      ST_PRESS2: begin
        if (!level) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (&cnt_q) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, counter and registered event outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ev_stb_q  <= 1'b0;
      ev_code_q <= EV_NONE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ev_stb_q  <= ev_stb_d;
      ev_code_q <= ev_code_d;
    end
  end

  assign ev_stb  = ev_stb_q;
  assign ev_code = ev_code_q;

endmodule
`default_nettype wire

// File: rtl/mouse_click_decoder.sv
`default_nettype none
// ============================================================================
// Module      : mouse_click_decoder
// Description : Synchronizes the 2-bit mouse button status, classifies
//               gestures per button and queues the resulting events in a
//               4-deep show-ahead FIFO with valid/ready handshake and a
//               sticky overflow flag. Define MOUSE_CLICK_DBLCLICK_EN to build
//               double-click detection.
// Revision    : 1.0 - initial release
// ============================================================================
module mouse_click_decoder
  import mouse_click_pkg::*;
#(
  parameter int unsigned DBL_WINDOW  = 12_500_000,
  parameter int unsigned HOLD_CYCLES = 25_000_000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] status_in,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       ev_btn,
  output logic [2:0] ev_code,
  output logic [1:0] btn_level,
  output logic       overflow,
  input  logic       ov_clr
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);

  // --------------------------------------------------------------------------
  // Input synchronizer plus edge-reference stage. fill_q tracks which stages
  // hold real samples since reset, so a button already held when reset is
  // released is never mistaken for a fresh press.
  // --------------------------------------------------------------------------
  logic [1:0] sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic [2:0] fill_q, fill_d;
  logic [1:0] press_edge;

  // Shift the button levels through the three-stage pipeline.
  always_comb begin
    sync1_d = status_in;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    fill_d  = {fill_q[1:0], 1'b1};
  end

  // Synchronizer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      fill_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
      fill_q  <= fill_d;
    end
  end

  assign press_edge = sync2_q & ~sync3_q & {2{fill_q[2]}};
  assign btn_level  = sync2_q;

  // --------------------------------------------------------------------------
  // Per-button gesture classifiers (bit 0 left, bit 1 right).
  // --------------------------------------------------------------------------
  logic [1:0] ev_stb;
  ev_code_t   ev_cd [2];

  for (genvar b = 0; b < 2; b++) begin : g_btn
    mouse_btn_fsm #(
      .DBL_WINDOW  (DBL_WINDOW),
      .HOLD_CYCLES (HOLD_CYCLES),
      .CNT_W       (CNT_W)
    ) u_fsm (
      .clk        (clk),
      .reset_n    (reset_n),
      .level      (sync2_q[b]),
      .press_edge (press_edge[b]),
      .ev_stb     (ev_stb[b]),
      .ev_code    (ev_cd[b])
    );
  end

  // --------------------------------------------------------------------------
  // Dual-write event FIFO. The left event always lands first; when space is
  // short the right event is the one dropped.
  // --------------------------------------------------------------------------
  fifo_entry_t [FIFO_DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]             rd_q, rd_d, wr_ptr;
  logic [OCC_W-1:0]             occ_q, occ_d, free;
  logic                         pop, wr_l, wr_r, drop;
  logic                         ov_q, ov_d;

  // Pop, free-slot accounting, writes and overflow update.
  always_comb begin
    mem_d  = mem_q;
    rd_d   = rd_q;
    pop    = (occ_q != '0) && ev_ready;
    // A same-cycle pop makes room before the writes are admitted.
    free   = OCC_W'(FIFO_DEPTH) - occ_q + OCC_W'(pop);
    wr_l   = ev_stb[0] && (free != '0);
    wr_r   = ev_stb[1] && (free > OCC_W'(wr_l));
    wr_ptr = rd_q + occ_q[PTR_W-1:0];
    if (wr_l) mem_d[wr_ptr] = '{btn: 1'b0, code: ev_cd[0]};
    if (wr_r) mem_d[wr_ptr + PTR_W'(wr_l)] = '{btn: 1'b1, code: ev_cd[1]};
    if (pop) rd_d = rd_q + PTR_W'(1);
    occ_d  = occ_q - OCC_W'(pop) + OCC_W'(wr_l) + OCC_W'(wr_r);
    drop   = (ev_stb[0] && !wr_l) || (ev_stb[1] && !wr_r);
    // A new drop outranks a clear in the same cycle.
    ov_d   = (ov_q && !ov_clr) || drop;
  end

  // FIFO storage, pointers and sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '0;
      rd_q  <= '0;
      occ_q <= '0;
      ov_q  <= 1'b0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
      ov_q  <= ov_d;
    end
  end

  assign ev_valid = (occ_q != '0);
  assign ev_btn   = ev_valid ? mem_q[rd_q].btn  : 1'b0;
  assign ev_code  = ev_valid ? mem_q[rd_q].code : EV_NONE;
  assign overflow = ov_q;

endmodule
`default_nettype wire

// File: tb/tb_mouse_click_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mouse_click_decoder
// Description : Self-checking bench for mouse_click_decoder with a timestamp
//               based gesture model and a queue-based FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mouse_click_decoder;

  localparam int DBL  = 8;
  localparam int HOLD = 16;
`ifdef MOUSE_CLICK_DBLCLICK_EN
  localparam int CLICK_LAT = 3 + DBL - 1;
`else
  localparam int CLICK_LAT = 3;
`endif

  logic       clk       = 1'b0;
  logic       reset_n   = 1'b0;
  logic [1:0] status_in = 2'b00;
  logic       ev_ready  = 1'b1;
  logic       ov_clr    = 1'b0;
  logic       ev_valid;
  logic       ev_btn;
  logic [2:0] ev_code;
  logic [1:0] btn_level;
  logic       overflow;

  int nchecks = 0;
  int nerrors = 0;

  mouse_click_decoder #(
    .DBL_WINDOW  (DBL),
    .HOLD_CYCLES (HOLD),
    .CNT_W       (26)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .status_in (status_in),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_btn    (ev_btn),
    .ev_code   (ev_code),
    .btn_level (btn_level),
    .overflow  (overflow),
    .ov_clr    (ov_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model. Gestures are judged by how many edges have elapsed since
  // the press or release that started them; the FIFO is a plain queue.
  // --------------------------------------------------------------------------
  int         mq[$];          // queued events, btn*8 + code
  logic [1:0] hist[$];        // samples of status_in, newest first
  int         pend[2];        // events classified on the previous edge
  int         phase[2];       // 0 none, 1 first press, 2 holding, 3 awaiting second press, 4 second press
  int         since[2];       // edge at which the current phase began
  int         tick;
  bit         m_ov;

  task automatic model_reset();
    mq.delete();
    hist.delete();
    for (int b = 0; b < 2; b++) begin
      pend[b]  = 0;
      phase[b] = 0;
      since[b] = 0;
    end
    m_ov = 1'b0;
    tick = 0;
  endtask

  function automatic int classify(input int b, input bit lvl, input bit rise);
    int ev = 0;
    int age = tick - since[b];
    case (phase[b])
      0: if (rise) begin phase[b] = 1; since[b] = tick; end
      1: begin
        if (!lvl) begin
`ifdef MOUSE_CLICK_DBLCLICK_EN
          phase[b] = 3; since[b] = tick;
`else
          ev = 1; phase[b] = 0;
`endif
        end else if (age == HOLD) begin
          ev = 3; phase[b] = 2;
        end
      end
      2: if (!lvl) begin ev = 4; phase[b] = 0; end
      3: begin
        if (rise) begin ev = 2; phase[b] = 4; end
        else if (age == DBL) begin ev = 1; phase[b] = 0; end
      end
      4: if (!lvl) phase[b] = 0;
      default: phase[b] = 0;
    endcase
    return ev;
  endfunction

  task automatic model_step(input logic [1:0] s, input bit rdy, input bit clr);
    int   free;
    bit   drop;
    logic [1:0] h2, h3;
    tick++;
    free = 4 - mq.size();
    if (rdy && mq.size() > 0) begin
      void'(mq.pop_front());
      free++;
    end
    drop = 1'b0;
    for (int b = 0; b < 2; b++) begin
      if (pend[b] != 0) begin
        if (free > 0) begin mq.push_back(b * 8 + pend[b]); free--; end
        else drop = 1'b1;
      end
    end
    m_ov = (m_ov && !clr) || drop;
    hist.push_front(s);
    if (hist.size() > 4) void'(hist.pop_back());
    h2 = (hist.size() >= 3) ? hist[2] : 2'b00;
    h3 = (hist.size() >= 4) ? hist[3] : 2'b11;
    for (int b = 0; b < 2; b++)
      pend[b] = classify(b, h2[b], h2[b] && !h3[b] && hist.size() >= 4);
  endtask

  // Compare process: every cycle, shortly after the active edge.
  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      model_reset();
      check("rst_ev_valid", int'(ev_valid), 0);
      check("rst_ev_btn", int'(ev_btn), 0);
      check("rst_ev_code", int'(ev_code), 0);
      check("rst_btn_level", int'(btn_level), 0);
      check("rst_overflow", int'(overflow), 0);
    end else begin
      model_step(status_in, ev_ready, ov_clr);
      check("ev_valid", int'(ev_valid), int'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("ev_btn", int'(ev_btn), mq[0] / 8);
        check("ev_code", int'(ev_code), mq[0] % 8);
      end
      check("btn_level", int'(btn_level), (hist.size() >= 2) ? int'(hist[1]) : 0);
      check("overflow", int'(overflow), int'(m_ov));
    end
  end

  // Edges after the sampling edge until ev_valid is seen; -1 on timeout.
  task automatic measure(output int lat);
    lat = -1;
    @(posedge clk);
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (ev_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  // Number of negedges within n at which ev_valid is high.
  task automatic count_valid(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (ev_valid) cnt++;
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;

    // Reset state.
    repeat (3) @(negedge clk);
    check("lit_rst_valid", int'(ev_valid), 0);
    check("lit_rst_code", int'(ev_code), 0);
    check("lit_rst_level", int'(btn_level), 0);
    check("lit_rst_ov", int'(overflow), 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Short left press.
    status_in = 2'b01;
    repeat (5) @(negedge clk);
    status_in = 2'b00;
    measure(lat);
    check("click_latency", lat, CLICK_LAT);
    check("click_btn", int'(ev_btn), 0);
    check("click_code", int'(ev_code), 1);
    repeat (12) @(negedge clk);

    // Right held long enough for HOLD_START, then released.
    status_in = 2'b10;
    measure(lat);
    check("hold_start_latency", lat, HOLD + 3);
    check("hold_start_btn", int'(ev_btn), 1);
    check("hold_start_code", int'(ev_code), 3);
    @(negedge clk);
    status_in = 2'b00;
    measure(lat);
    check("hold_end_latency", lat, 3);
    check("hold_end_btn", int'(ev_btn), 1);
    check("hold_end_code", int'(ev_code), 4);
    repeat (5) @(negedge clk);

    // Both buttons released together: left entry first, right next.
    status_in = 2'b11;
    repeat (4) @(negedge clk);
    status_in = 2'b00;
    measure(lat);
    check("dual_latency", lat, CLICK_LAT);
    check("dual_first_btn", int'(ev_btn), 0);
    check("dual_first_code", int'(ev_code), 1);
    @(posedge clk);
    #1;
    check("dual_second_valid", int'(ev_valid), 1);
    check("dual_second_btn", int'(ev_btn), 1);
    check("dual_second_code", int'(ev_code), 1);
    repeat (15) @(negedge clk);

`ifdef MOUSE_CLICK_DBLCLICK_EN
    // Press 3 / gap 4 / press: exactly one DOUBLE and no CLICK.
    status_in = 2'b01;
    repeat (3) @(negedge clk);
    status_in = 2'b00;
    repeat (4) @(negedge clk);
    status_in = 2'b01;
    measure(lat);
    check("double_latency", lat, 3);
    check("double_code", int'(ev_code), 2);
    @(negedge clk);
    status_in = 2'b00;
    count_valid(20, n);
    check("double_no_click", n, 0);
    // Gap of 9 exceeds the window: two separate clicks.
    status_in = 2'b01;
    repeat (3) @(negedge clk);
    status_in = 2'b00;
    repeat (9) @(negedge clk);
    status_in = 2'b01;
    repeat (3) @(negedge clk);
    status_in = 2'b00;
    count_valid(20, n);
    check("slow_pair_clicks", n, 1);
    repeat (5) @(negedge clk);
`endif

    // Five clicks with the consumer stalled: four kept, overflow set.
    ev_ready = 1'b0;
    repeat (5) begin
      status_in = 2'b01;
      repeat (3) @(negedge clk);
      status_in = 2'b00;
      repeat (12) @(negedge clk);
    end
    check("ovf_flag", int'(overflow), 1);
    check("ovf_valid", int'(ev_valid), 1);
    ov_clr = 1'b1;
    @(negedge clk);
    ov_clr = 1'b0;
    check("ovf_cleared", int'(overflow), 0);
    ev_ready = 1'b1;
    n = 0;
    repeat (8) begin
      if (ev_valid) begin
        n++;
        check("drain_btn", int'(ev_btn), 0);
        check("drain_code", int'(ev_code), 1);
      end
      @(negedge clk);
    end
    check("drain_count", n, 4);

    // Reset while the left button is held past the hold limit.
    status_in = 2'b01;
    repeat (22) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", int'(ev_valid), 0);
    check("midrst_level", int'(btn_level), 0);
    check("midrst_ov", int'(overflow), 0);
    reset_n = 1'b1;
    count_valid(10, n);
    status_in = 2'b00;
    count_valid(15, lat);
    check("midrst_no_event", n + lat, 0);
    status_in = 2'b01;
    repeat (4) @(negedge clk);
    status_in = 2'b00;
    measure(lat);
    check("post_rst_click_latency", lat, CLICK_LAT);
    check("post_rst_click_code", int'(ev_code), 1);
    repeat (10) @(negedge clk);

    // Randomized traffic against the model.
    for (int seg = 0; seg < 250; seg++) begin
      @(negedge clk);
      status_in = 2'($urandom_range(0, 3));
      ev_ready  = ($urandom_range(0, 9) >= 3);
      ov_clr    = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 60) == 0) begin
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
      end
      repeat ($urandom_range(0, 24)) begin
        @(negedge clk);
        ov_clr = 1'b0;
      end
      ov_clr = 1'b0;
    end
    status_in = 2'b00;
    ev_ready  = 1'b1;
    repeat (30) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
`default_nettype wire
